regfile_mport: RTL and testbench
================================

REGFILE_MPORT -- requirements
Module: regfile_mport

Interface
REQ-001 Parameter RWIDTH, default 5, register address width; depth = 2**RWIDTH.
REQ-002 Parameter DWIDTH, default 32, data width.
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 ra  input  NRD x RWIDTH  read addresses.
REQ-007 rd  output  NRD x DWIDTH  read data.
REQ-008 busy  output  NRD  pending-write flag for each ra.
REQ-009 we0, we1  input  1 each  write enables, ports 0 and 1.
REQ-010 wa0, wa1  input  RWIDTH each  write addresses.
REQ-011 wd0, wd1  input  DWIDTH each  write data.
REQ-012 rsv_en  input  1  reserve request; marks rsv_addr pending.
REQ-013 rsv_addr  input  RWIDTH  register to reserve.
REQ-014 pend_cnt  output  RWIDTH+1  number of pending registers.

Function
REQ-015 Register 0 SHALL always read 0; writes and reserves to address 0 are ignored.
REQ-016 Reads SHALL be combinational from ra; rd[i] reflects register state with no clock latency.
REQ-017 A write with weN=1 and waN!=0 SHALL update the register at the next rising edge.
REQ-018 When we0 and we1 both target the same non-zero address, port 1 SHALL win.
REQ-019 Scoreboard: one pending bit per register; rsv_en with rsv_addr!=0 SHALL set the bit at the next edge.
REQ-020 A write (either port) to a pending register SHALL clear its bit at the next edge.
REQ-021 A reserve and a write to the same address in the same cycle SHALL leave the bit set (new reservation wins); the data write still occurs.
REQ-022 A reserve to an already-pending register SHALL leave it pending; pend_cnt unchanged.
REQ-023 busy[i] SHALL equal the pending bit of ra[i], combinationally; busy for address 0 is always 0.
REQ-024 pend_cnt SHALL be a registered count equal to the number of set pending bits after each edge; max 2**RWIDTH-1, no wrap.

Reset
REQ-025 rst_n low SHALL asynchronously clear all registers to 0, all pending bits to 0 and pend_cnt to 0.
REQ-026 While rst_n is low, rd SHALL read 0 and busy SHALL be 0; writes and reserves SHALL be ignored.
REQ-027 Reset asserted mid-operation SHALL discard same-cycle writes and reserves; first update after release on the first rising edge with rst_n high.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN defined: a read whose ra matches an enabled non-zero write address in the same cycle SHALL return that write data (port 1 data if both match), and busy SHALL read 0 for that port unless the same cycle also reserves the address.
REQ-029 Macro REGFILE_BYPASS_EN undefined: reads SHALL return the pre-edge stored value; busy reflects only stored pending bits.

Structure
REQ-030 Shared package regfile_pkg SHALL hold default RWIDTH/DWIDTH constants and a typedef for the write-request bundle (we, wa, wd).
REQ-031 Scoreboard (pending bits, pend_cnt) SHALL be a sub-module named regfile_scoreboard; storage and bypass stay in regfile_mport.

Verification
REQ-032 Reset, then read all addresses -> rd=0, busy=0, pend_cnt=0.
REQ-033 we0=1, wa0=3, wd0=32'hDEADBEEF; next cycle ra[0]=3 -> rd[0]=32'hDEADBEEF; write wa0=0 wd0=32'h1 -> ra=0 reads 0.
REQ-034 we0 wa0=5 wd0=32'h11 and we1 wa1=5 wd1=32'h22 same cycle -> reg5=32'h22.
REQ-035 rsv_en rsv_addr=7 -> next cycle busy=1 for ra=7, pend_cnt=1; write wa1=7 -> next cycle busy=0, pend_cnt=0; reserve and write 7 together -> busy stays 1.
REQ-036 With REGFILE_BYPASS_EN: we0 wa0=9 wd0=32'hA5A5A5A5, ra[1]=9 same cycle -> rd[1]=32'hA5A5A5A5; without macro -> rd[1]=old value 0.
REQ-037 Reserve registers 1..4, assert rst_n low between edges -> pend_cnt=0 and busy=0 immediately, registers read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and the write-request bundle for the multi-port register file.
package regfile_pkg;

  localparam int DEF_RWIDTH = 5;
  localparam int DEF_DWIDTH = 32;
  localparam int NWR        = 2;

  // Bundle fields are sized for the widest supported instance; narrower instances zero-extend.
  localparam int MAX_RWIDTH = 16;
  localparam int MAX_DWIDTH = 64;

  typedef struct packed {
    logic                  we;
    logic [MAX_RWIDTH-1:0] wa;
    logic [MAX_DWIDTH-1:0] wd;
  } wr_req_t;

  function automatic logic wr_valid(input logic we, input logic [MAX_RWIDTH-1:0] wa);
    return we && (wa != '0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register plus a registered population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int RWIDTH = DEF_RWIDTH,
  parameter int NWP    = NWR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NWP-1:0]             wr_en_i,
  input  logic [NWP-1:0][RWIDTH-1:0] wr_addr_i,
  input  logic                       rsv_en_i,
  input  logic [RWIDTH-1:0]          rsv_addr_i,
  output logic [2**RWIDTH-1:0]       pend_o,
  output logic [RWIDTH:0]            pend_cnt_o
);

  localparam int DEPTH = 2**RWIDTH;
  localparam int CW    = RWIDTH + 1;

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    pend_d = pend_q;
    for (int p = 0; p < NWP; p++) begin
      if (wr_en_i[p]) pend_d[wr_addr_i[p]] = 1'b0;
    end
    // Reserve applied after the clears so a same-cycle reserve and write leaves the bit set.
    if (rsv_en_i) pend_d[rsv_addr_i] = 1'b1;
    pend_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 1; i < DEPTH; i++) begin
      cnt_d = cnt_d + CW'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mport.sv
// Multi-port register file: NRD combinational reads, two write ports, pending-write scoreboard.
// Defining REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile_mport
  import regfile_pkg::*;
#(
  parameter int RWIDTH = DEF_RWIDTH,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int NRD    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NRD-1:0][RWIDTH-1:0] ra,
  output logic [NRD-1:0][DWIDTH-1:0] rd,
  output logic [NRD-1:0]             busy,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [RWIDTH-1:0]          wa0,
  input  logic [RWIDTH-1:0]          wa1,
  input  logic [DWIDTH-1:0]          wd0,
  input  logic [DWIDTH-1:0]          wd1,
  input  logic                       rsv_en,
  input  logic [RWIDTH-1:0]          rsv_addr,
  output logic [RWIDTH:0]            pend_cnt
);

  localparam int DEPTH = 2**RWIDTH;

  wr_req_t [NWR-1:0]             wr_req;
  logic [NWR-1:0]                wr_en;
  logic [NWR-1:0][RWIDTH-1:0]    wr_addr;
  logic [DWIDTH-1:0]             regs_q [DEPTH];
  logic [DEPTH-1:0]              pend;

  assign wr_req[0] = '{we: we0, wa: MAX_RWIDTH'(wa0), wd: MAX_DWIDTH'(wd0)};
  assign wr_req[1] = '{we: we1, wa: MAX_RWIDTH'(wa1), wd: MAX_DWIDTH'(wd1)};

  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr
      assign wr_en[gi]   = wr_valid(wr_req[gi].we, wr_req[gi].wa);
      assign wr_addr[gi] = RWIDTH'(wr_req[gi].wa);
    end
  endgenerate

  // Port 1 is assigned last, so it wins when both ports hit the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p]) regs_q[wr_addr[p]] <= DWIDTH'(wr_req[p].wd);
      end
    end
  end

  regfile_scoreboard #(
    .RWIDTH (RWIDTH),
    .NWP    (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .pend_o     (pend),
    .pend_cnt_o (pend_cnt)
  );

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [DWIDTH-1:0] data;
      logic              bsy;

      always_comb begin
        data = regs_q[ra[gi]];
        bsy  = pend[ra[gi]];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && (wr_addr[p] == ra[gi])) begin
            data = DWIDTH'(wr_req[p].wd);
            bsy  = rsv_en && (rsv_addr == ra[gi]);
          end
        end
`endif
      end

      // Outputs held quiet while reset is asserted, even if a write is being driven.
      assign rd[gi]   = rst_n ? data : '0;
      assign busy[gi] = rst_n & bsy;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mport.sv
// Randomised self-checking bench for regfile_mport against an architectural reference model.
module tb_regfile_mport;

  localparam int RW    = 5;
  localparam int DW    = 32;
  localparam int NRD   = 2;
  localparam int DEPTH = 2**RW;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NRD-1:0][RW-1:0] ra;
  logic [NRD-1:0][DW-1:0] rd;
  logic [NRD-1:0]         busy;
  logic                  we0, we1, rsv_en;
  logic [RW-1:0]         wa0, wa1, rsv_addr;
  logic [DW-1:0]         wd0, wd1;
  logic [RW:0]           pend_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem_m  [DEPTH];
  bit            pend_m [DEPTH];

  always #5 clk = ~clk;

  regfile_mport #(.RWIDTH(RW), .DWIDTH(DW), .NRD(NRD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rd       (rd),
    .busy     (busy),
    .we0      (we0),
    .we1      (we1),
    .wa0      (wa0),
    .wa1      (wa1),
    .wd0      (wd0),
    .wd1      (wd1),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .pend_cnt (pend_cnt)
  );

  // Architectural state after each edge: register contents and the set of pending registers.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_m[i]  <= '0;
        pend_m[i] <= 1'b0;
      end
    end else begin
      if (we0 && wa0 != 0) begin mem_m[wa0] <= wd0; pend_m[wa0] <= 1'b0; end
      if (we1 && wa1 != 0) begin mem_m[wa1] <= wd1; pend_m[wa1] <= 1'b0; end
      if (rsv_en && rsv_addr != 0) pend_m[rsv_addr] <= 1'b1;
    end
  end

  function automatic int count_pend();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(pend_m[i]);
    return n;
  endfunction

  function automatic void exp_port(input int i, output logic [DW-1:0] d, output logic b);
    int a;
    a = int'(ra[i]);
    d = '0;
    b = 1'b0;
    if (rst_n) begin
      d = mem_m[a];
      b = pend_m[a];
`ifdef REGFILE_BYPASS_EN
      if (we1 && int'(wa1) == a && a != 0) begin
        d = wd1;
        b = rsv_en && int'(rsv_addr) == a;
      end else if (we0 && int'(wa0) == a && a != 0) begin
        d = wd0;
        b = rsv_en && int'(rsv_addr) == a;
      end
`endif
    end
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every cycle: outputs against the reference, sampled mid-low-phase.
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    logic          eb;
    #2;
    for (int i = 0; i < NRD; i++) begin
      exp_port(i, ed, eb);
      check($sformatf("model rd[%0d] ra=%0d", i, ra[i]), 64'(rd[i]), 64'(ed));
      check($sformatf("model busy[%0d] ra=%0d", i, ra[i]), 64'(busy[i]), 64'(eb));
    end
    check("model pend_cnt", 64'(pend_cnt), rst_n ? 64'(count_pend()) : 64'd0);
  end

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    rsv_en = 1'b0; rsv_addr = '0; ra = '0;
  endtask

  function automatic logic [RW-1:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return RW'($urandom_range(0, 3));
    return RW'($urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("in_reset rd0", 64'(rd[0]), 64'd0);
    check("in_reset pend_cnt", 64'(pend_cnt), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Post-reset sweep of every address.
    for (int a = 0; a < DEPTH; a += 2) begin
      @(negedge clk); idle(); ra[0] = RW'(a); ra[1] = RW'(a + 1);
      #3;
      check("sweep rd0", 64'(rd[0]), 64'd0);
      check("sweep rd1", 64'(rd[1]), 64'd0);
      check("sweep busy", 64'(busy), 64'd0);
      check("sweep pend_cnt", 64'(pend_cnt), 64'd0);
    end

    // Basic write/read and register 0.
    @(negedge clk); idle(); we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF;
    @(negedge clk); idle(); ra[0] = 5'd3; we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1;
    #3 check("wr3 rd0", 64'(rd[0]), 64'hDEADBEEF);
    @(negedge clk); idle(); ra[0] = 5'd0;
    #3 check("reg0 rd0", 64'(rd[0]), 64'd0);

    // Dual write collision: port 1 wins.
    @(negedge clk); idle(); we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11; we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h22;
    @(negedge clk); idle(); ra[1] = 5'd5;
    #3 check("collide rd1", 64'(rd[1]), 64'h22);

    // Reserve, clear by write, reserve+write together.
    @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 5'd7;
    @(negedge clk); idle(); ra[0] = 5'd7;
    #3 check("rsv7 busy0", 64'(busy[0]), 64'd1);
    check("rsv7 pend_cnt", 64'(pend_cnt), 64'd1);
    @(negedge clk); idle(); we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h77;
    @(negedge clk); idle(); ra[0] = 5'd7;
    #3 check("clr7 busy0", 64'(busy[0]), 64'd0);
    check("clr7 pend_cnt", 64'(pend_cnt), 64'd0);
    check("clr7 rd0", 64'(rd[0]), 64'h77);
    @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 5'd7; we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h88;
    @(negedge clk); idle(); ra[0] = 5'd7;
    #3 check("rsvwr7 busy0", 64'(busy[0]), 64'd1);
    check("rsvwr7 pend_cnt", 64'(pend_cnt), 64'd1);
    check("rsvwr7 rd0", 64'(rd[0]), 64'h88);

    // Same-cycle read of a register being written.
    @(negedge clk); idle(); we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5A5A5A5; ra[1] = 5'd9;
`ifdef REGFILE_BYPASS_EN
    #3 check("bypass rd1", 64'(rd[1]), 64'hA5A5A5A5);
`else
    #3 check("nobypass rd1", 64'(rd[1]), 64'd0);
`endif
    check("bypass busy1", 64'(busy[1]), 64'd0);
    @(negedge clk); idle(); ra[1] = 5'd9;
    #3 check("wr9 rd1", 64'(rd[1]), 64'hA5A5A5A5);

    // Reserve 1..4, then reset between edges.
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = RW'(r);
    end
    @(negedge clk); idle(); ra[0] = 5'd2; ra[1] = 5'd7;
    #3 check("rsv1to4 pend_cnt", 64'(pend_cnt), 64'd5);
    check("rsv1to4 busy", 64'(busy), 64'b11);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrst pend_cnt", 64'(pend_cnt), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst rd1", 64'(rd[1]), 64'd0);
    @(negedge clk); rst_n = 1'b1; idle(); ra[0] = 5'd3; ra[1] = 5'd7;
    #3 check("postrst rd0", 64'(rd[0]), 64'd0);
    check("postrst rd1", 64'(rd[1]), 64'd0);

    // Fill the scoreboard: count tops out at DEPTH-1 and a repeat reserve does not move it.
    for (int r = 0; r < DEPTH; r++) begin
      @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = RW'(r);
    end
    @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 5'd31; ra[0] = 5'd31; ra[1] = 5'd0;
    #3 check("full pend_cnt", 64'(pend_cnt), 64'd31);
    check("full busy", 64'(busy), 64'b01);
    @(negedge clk); idle();
    #3 check("rersv pend_cnt", 64'(pend_cnt), 64'd31);

    // Randomised traffic with occasional mid-cycle resets.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst_n    = 1'b1;
      we0      = 1'($urandom_range(0, 1));
      we1      = 1'($urandom_range(0, 1));
      wa0      = pick_addr();
      wa1      = pick_addr();
      wd0      = $urandom;
      wd1      = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = pick_addr();
      for (int i = 0; i < NRD; i++) ra[i] = pick_addr();
      if ($urandom_range(0, 79) == 0) #1 rst_n = 1'b0;
    end
    @(negedge clk); rst_n = 1'b1; idle();
    @(negedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
